// File: rtl/link_trainer.sv
// Lane bring-up: aligner reset, 5/A training pattern, timeout/retry search, verify, hold, then payload.
// Macro LINK_TRAINER_RETRAIN_EN: loss of link retrains from RST instead of flagging and staying linked.
module link_trainer #(
    parameter int w           = 128,
    parameter int TIMEOUT     = 1024,
    parameter int MAX_RETRY   = 4,
    parameter int VERIFY_N    = 8,
    parameter int HOLD_CYCLES = 16,
    parameter int ERR_MAX     = 4,
    localparam int RW         = $clog2(MAX_RETRY + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic          align_aligned,
    input  logic [w-1:0]  rx_data,
    input  logic          rx_err,
    input  logic [w-1:0]  tx_payload,
    output logic          align_rst_n,
    output logic [w-1:0]  tx_data,
    output logic          link_up,
    output logic          link_fail,
    output logic          link_err,
    output logic [RW-1:0] retry_cnt,
    output logic [2:0]    state
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int GW = $clog2(VERIFY_N + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int EW = $clog2(ERR_MAX + 1);
    localparam logic [w-1:0] P5 = {(w/4){4'h5}};
    localparam logic [w-1:0] PA = {(w/4){4'ha}};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_RST = 3'd1, S_SEARCH = 3'd2, S_VERIFY = 3'd3,
        S_HOLD = 3'd4, S_LINKED = 3'd5, S_FAIL = 3'd6
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    rst_cnt_q, rst_cnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [RW-1:0] retry_q, retry_d, retry_inc;
    logic [GW-1:0] good_q, good_d;
    logic [w-1:0]  prev_q, prev_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [7:0]    win_q, win_d;
    logic [EW-1:0] err_q, err_d;
    logic          phase_q, phase_d;
    logic [w-1:0]  tx_q, tx_d;
    logic          align_rst_n_q, align_rst_n_d;
    logic          link_up_q, link_up_d;
    logic          link_fail_q, link_fail_d;
    logic          link_err_q, link_err_d;
    logic          good_word, enter_rst;

    // The first verify word is compared against a cleared prev_q, so either pattern word counts.
    assign good_word = ((rx_data == P5) || (rx_data == PA)) && (rx_data != prev_q);
    assign retry_inc = retry_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        rst_cnt_d  = '0;
        timer_d    = timer_q;
        retry_d    = retry_q;
        good_d     = '0;
        prev_d     = '0;
        hold_d     = '0;
        win_d      = '0;
        err_d      = '0;
        link_err_d = link_err_q;
        case (state_q)
            S_IDLE, S_FAIL: begin
                if (start) begin
                    state_d    = S_RST;
                    retry_d    = '0;
                    link_err_d = 1'b0;
                end
            end
            S_RST: begin
                rst_cnt_d = rst_cnt_q + 1'b1;
                timer_d   = '0;
                if (rst_cnt_q == 2'd3) state_d = S_SEARCH;
            end
            S_SEARCH, S_VERIFY: begin
                timer_d = timer_q + 1'b1;
                if (state_q == S_VERIFY) begin
                    prev_d = rx_data;
                    good_d = good_word ? good_q + 1'b1 : '0;
                end
                if (timer_q == TW'(TIMEOUT - 1)) begin
                    timer_d = '0;
                    good_d  = '0;
                    retry_d = retry_inc;
                    state_d = (retry_inc == RW'(MAX_RETRY)) ? S_FAIL : S_RST;
                end else if (state_q == S_SEARCH && align_aligned) begin
                    state_d = S_VERIFY;
                end else if (state_q == S_VERIFY && good_d == GW'(VERIFY_N)) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                hold_d = hold_q + 1'b1;
                if (hold_q == HW'(HOLD_CYCLES - 1)) state_d = S_LINKED;
            end
            S_LINKED: begin
                win_d = win_q + 1'b1;
                // A pulse landing on the wrap edge belongs to the new window.
                if (win_q == 8'hff)
                    err_d = rx_err ? EW'(1) : '0;
                else if (rx_err && err_q != EW'(ERR_MAX))
                    err_d = err_q + 1'b1;
                else
                    err_d = err_q;
                if (err_d == EW'(ERR_MAX)) begin
                    link_err_d = 1'b1;
`ifdef LINK_TRAINER_RETRAIN_EN
                    retry_d = '0;
                    err_d   = '0;
                    state_d = S_RST;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign enter_rst = (state_d == S_RST) && (state_q != S_RST);

    always_comb begin
        tx_d          = '0;
        phase_d       = phase_q;
        align_rst_n_d = !(state_d inside {S_IDLE, S_RST, S_FAIL});
        link_up_d     = (state_d == S_LINKED);
        link_fail_d   = (state_d == S_FAIL);
        case (state_d)
            S_RST, S_SEARCH, S_VERIFY, S_HOLD: begin
                if (enter_rst) begin
                    tx_d    = P5;
                    phase_d = 1'b1;
                end else begin
                    tx_d    = phase_q ? PA : P5;
                    phase_d = ~phase_q;
                end
            end
            S_LINKED: tx_d = tx_payload;
            default:  tx_d = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            rst_cnt_q     <= '0;
            timer_q       <= '0;
            retry_q       <= '0;
            good_q        <= '0;
            prev_q        <= '0;
            hold_q        <= '0;
            win_q         <= '0;
            err_q         <= '0;
            phase_q       <= 1'b0;
            tx_q          <= '0;
            align_rst_n_q <= 1'b0;
            link_up_q     <= 1'b0;
            link_fail_q   <= 1'b0;
            link_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            rst_cnt_q     <= rst_cnt_d;
            timer_q       <= timer_d;
            retry_q       <= retry_d;
            good_q        <= good_d;
            prev_q        <= prev_d;
            hold_q        <= hold_d;
            win_q         <= win_d;
            err_q         <= err_d;
            phase_q       <= phase_d;
            tx_q          <= tx_d;
            align_rst_n_q <= align_rst_n_d;
            link_up_q     <= link_up_d;
            link_fail_q   <= link_fail_d;
            link_err_q    <= link_err_d;
        end
    end

    assign align_rst_n = align_rst_n_q;
    assign tx_data     = tx_q;
    assign link_up     = link_up_q;
    assign link_fail   = link_fail_q;
    assign link_err    = link_err_q;
    assign retry_cnt   = retry_q;
    assign state       = state_q;
endmodule

// File: tb/tb_link_trainer.sv
// Bench for link_trainer: randomized bring-up, retry, verify glitch, error-window and reset scenarios.
`timescale 1ns/1ps
module tb_link_trainer;
    localparam int W = 128, TIMEOUT = 1024, MAX_RETRY = 4, VERIFY_N = 8, HOLD_CYCLES = 16, ERR_MAX = 4;
    localparam int PER = TIMEOUT + 4;
    localparam logic [W-1:0] P5 = {(W/4){4'h5}};
    localparam logic [W-1:0] PA = {(W/4){4'ha}};
    localparam logic [2:0] ST_IDLE = 3'd0, ST_RST = 3'd1, ST_SEARCH = 3'd2, ST_VERIFY = 3'd3,
                           ST_HOLD = 3'd4, ST_LINKED = 3'd5, ST_FAIL = 3'd6;

    logic clock, reset, start, align_aligned, rx_err, loopback;
    logic [W-1:0] rx_drv, rx_data, tx_payload, tx_data;
    logic align_rst_n, link_up, link_fail, link_err;
    logic [2:0] retry_cnt, state;
    int n_checks, n_fail, cyc, t_link;

    assign rx_data = loopback ? tx_data : rx_drv;

    link_trainer #(.w(W), .TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY), .VERIFY_N(VERIFY_N),
                   .HOLD_CYCLES(HOLD_CYCLES), .ERR_MAX(ERR_MAX)) dut (
        .clock(clock), .reset(reset), .start(start), .align_aligned(align_aligned),
        .rx_data(rx_data), .rx_err(rx_err), .tx_payload(tx_payload),
        .align_rst_n(align_rst_n), .tx_data(tx_data), .link_up(link_up),
        .link_fail(link_fail), .link_err(link_err), .retry_cnt(retry_cnt), .state(state));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    function automatic logic [W-1:0] pat(int k);
        return (k % 2 == 0) ? P5 : PA;
    endfunction

    function automatic logic [W-1:0] rand_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic test_reset();
        reset = 1'b0; start = 1'b1; align_aligned = 1'b1; rx_err = 1'b1;
        step(); step();
        start = 1'b0; align_aligned = 1'b0; rx_err = 1'b0;
        n_checks++; if (state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", state, ST_IDLE); end
        n_checks++; if (align_rst_n !== 1'b0) begin n_fail++; $display("FAIL reset_align_rst_n: got %b want 0", align_rst_n); end
        n_checks++; if (tx_data !== '0) begin n_fail++; $display("FAIL reset_tx_data: got %h want 0", tx_data); end
        n_checks++; if (link_up !== 1'b0) begin n_fail++; $display("FAIL reset_link_up: got %b want 0", link_up); end
        n_checks++; if (link_fail !== 1'b0) begin n_fail++; $display("FAIL reset_link_fail: got %b want 0", link_fail); end
        n_checks++; if (link_err !== 1'b0) begin n_fail++; $display("FAIL reset_link_err: got %b want 0", link_err); end
        n_checks++; if (retry_cnt !== 3'd0) begin n_fail++; $display("FAIL reset_retry_cnt: got %0d want 0", retry_cnt); end
        reset = 1'b1;
        step();
        n_checks++; if (state !== ST_IDLE) begin n_fail++; $display("FAIL idle_after_reset: got %0d want %0d", state, ST_IDLE); end
    endtask

    task automatic test_clean_bringup();
        int s, d;
        logic [W-1:0] old_p, new_p;
        loopback = 1'b1; align_aligned = 1'b0; tx_payload = rand_word();
        start = 1'b1; step(); start = 1'b0; s = cyc;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (state !== ST_RST) begin n_fail++; $display("FAIL bring_rst_state: got %0d want %0d", state, ST_RST); end
            n_checks++; if (align_rst_n !== 1'b0) begin n_fail++; $display("FAIL bring_rst_align: got %b want 0", align_rst_n); end
            n_checks++; if (tx_data !== pat(cyc - s)) begin n_fail++; $display("FAIL bring_rst_tx: got %h want %h", tx_data, pat(cyc - s)); end
            step();
        end
        d = $urandom_range(3, 40);
        for (int i = 0; i < d; i++) begin
            n_checks++; if (state !== ST_SEARCH) begin n_fail++; $display("FAIL bring_search_state: got %0d want %0d", state, ST_SEARCH); end
            n_checks++; if (align_rst_n !== 1'b1) begin n_fail++; $display("FAIL bring_search_align: got %b want 1", align_rst_n); end
            n_checks++; if (tx_data !== pat(cyc - s)) begin n_fail++; $display("FAIL bring_search_tx: got %h want %h", tx_data, pat(cyc - s)); end
            if (i == d - 1) align_aligned = 1'b1;
            step();
        end
        for (int i = 0; i < VERIFY_N; i++) begin
            n_checks++; if (state !== ST_VERIFY) begin n_fail++; $display("FAIL bring_verify_state: got %0d want %0d", state, ST_VERIFY); end
            n_checks++; if (tx_data !== pat(cyc - s)) begin n_fail++; $display("FAIL bring_verify_tx: got %h want %h", tx_data, pat(cyc - s)); end
            step();
        end
        for (int i = 0; i < HOLD_CYCLES; i++) begin
            n_checks++; if (state !== ST_HOLD) begin n_fail++; $display("FAIL bring_hold_state: got %0d want %0d", state, ST_HOLD); end
            n_checks++; if (tx_data !== pat(cyc - s)) begin n_fail++; $display("FAIL bring_hold_tx: got %h want %h", tx_data, pat(cyc - s)); end
            n_checks++; if (link_up !== 1'b0) begin n_fail++; $display("FAIL bring_hold_link_up: got %b want 0", link_up); end
            step();
        end
        t_link = cyc;
        n_checks++; if (state !== ST_LINKED) begin n_fail++; $display("FAIL bring_linked_state: got %0d want %0d", state, ST_LINKED); end
        n_checks++; if (link_up !== 1'b1) begin n_fail++; $display("FAIL bring_link_up: got %b want 1", link_up); end
        n_checks++; if (retry_cnt !== 3'd0) begin n_fail++; $display("FAIL bring_retry_cnt: got %0d want 0", retry_cnt); end
        n_checks++; if (tx_data !== tx_payload) begin n_fail++; $display("FAIL bring_first_payload: got %h want %h", tx_data, tx_payload); end
        for (int i = 0; i < 6; i++) begin
            old_p = tx_payload; new_p = rand_word(); tx_payload = new_p;
            #1;
            n_checks++; if (tx_data !== old_p) begin n_fail++; $display("FAIL payload_hold: got %h want %h", tx_data, old_p); end
            step();
            n_checks++; if (tx_data !== new_p) begin n_fail++; $display("FAIL payload_latency: got %h want %h", tx_data, new_p); end
        end
    endtask

    task automatic test_window_wrap();
        int b, last, wi, cur_w, cur_n;
        int pq[$];
        bit lost;
        b = t_link + 256 * ((cyc - t_link) / 256 + 1);
        if (b - cyc < 24) b += 256;
        pq.push_back(b - $urandom_range(11, 20));
        pq.push_back(b - $urandom_range(1, 10));
        pq.push_back(b + $urandom_range(0, 9));
        pq.push_back(b + $urandom_range(10, 19));
        last = pq[3] + 3; lost = 0; cur_w = -1; cur_n = 0;
        while (cyc < last) begin
            rx_err = (pq.size() != 0 && pq[0] == cyc + 1);
            step();
            if (rx_err) begin
                pq.delete(0);
                wi = (cyc - t_link) / 256;
                if (wi != cur_w) begin cur_w = wi; cur_n = 0; end
                cur_n++;
                if (cur_n >= ERR_MAX) lost = 1;
            end
            rx_err = 1'b0;
            n_checks++; if (link_err !== lost) begin n_fail++; $display("FAIL wrap_link_err: got %b want %b", link_err, lost); end
            n_checks++; if (state !== ST_LINKED) begin n_fail++; $display("FAIL wrap_state: got %0d want %0d", state, ST_LINKED); end
        end
    endtask

    task automatic test_loss_of_link();
        int b, o, last, wi, cur_w, cur_n;
        int pq[$];
        bit lost;
        b = t_link + 256 * ((cyc - t_link) / 256 + 1);
        o = 0;
        for (int i = 0; i < ERR_MAX; i++) begin o += $urandom_range(1, 60); pq.push_back(b + o); end
        last = b + o + 5; lost = 0; cur_w = -1; cur_n = 0;
        while (cyc < last) begin
            rx_err = (pq.size() != 0 && pq[0] == cyc + 1);
            step();
            if (rx_err) begin
                pq.delete(0);
                wi = (cyc - t_link) / 256;
                if (wi != cur_w) begin cur_w = wi; cur_n = 0; end
                cur_n++;
                if (cur_n >= ERR_MAX) lost = 1;
            end
            rx_err = 1'b0;
            n_checks++; if (link_err !== lost) begin n_fail++; $display("FAIL loss_link_err: got %b want %b", link_err, lost); end
`ifdef LINK_TRAINER_RETRAIN_EN
            if (lost) begin
                n_checks++; if (state !== ST_RST) begin n_fail++; $display("FAIL loss_state: got %0d want %0d", state, ST_RST); end
                n_checks++; if (link_up !== 1'b0) begin n_fail++; $display("FAIL loss_link_up: got %b want 0", link_up); end
                n_checks++; if (retry_cnt !== 3'd0) begin n_fail++; $display("FAIL loss_retry_cnt: got %0d want 0", retry_cnt); end
                break;
            end
            n_checks++; if (link_up !== 1'b1) begin n_fail++; $display("FAIL loss_pre_link_up: got %b want 1", link_up); end
`else
            n_checks++; if (link_up !== 1'b1) begin n_fail++; $display("FAIL loss_link_up: got %b want 1", link_up); end
            n_checks++; if (state !== ST_LINKED) begin n_fail++; $display("FAIL loss_state: got %0d want %0d", state, ST_LINKED); end
`endif
        end
        n_checks++; if (link_err !== 1'b1) begin n_fail++; $display("FAIL loss_final_link_err: got %b want 1", link_err); end
    endtask

    task automatic test_timeout_retry();
        int s, k, r;
        reset = 1'b0; step(); reset = 1'b1;
        loopback = 1'b1; align_aligned = 1'b0;
        start = 1'b1; step(); start = 1'b0; s = cyc;
        while (cyc < s + MAX_RETRY * PER) begin
            k = (cyc - s) % PER; r = (cyc - s) / PER;
            n_checks++; if (state !== ((k < 4) ? ST_RST : ST_SEARCH)) begin n_fail++; $display("FAIL retry_state: got %0d at offset %0d", state, cyc - s); end
            n_checks++; if (align_rst_n !== (k >= 4)) begin n_fail++; $display("FAIL retry_align: got %b at offset %0d", align_rst_n, cyc - s); end
            n_checks++; if (retry_cnt !== 3'(r)) begin n_fail++; $display("FAIL retry_cnt: got %0d want %0d", retry_cnt, r); end
            n_checks++; if (tx_data !== pat(k)) begin n_fail++; $display("FAIL retry_tx: got %h want %h", tx_data, pat(k)); end
            start = (cyc == s + PER + 100);
            step();
            start = 1'b0;
        end
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (state !== ST_FAIL) begin n_fail++; $display("FAIL fail_state: got %0d want %0d", state, ST_FAIL); end
            n_checks++; if (link_fail !== 1'b1) begin n_fail++; $display("FAIL fail_link_fail: got %b want 1", link_fail); end
            n_checks++; if (retry_cnt !== 3'(MAX_RETRY)) begin n_fail++; $display("FAIL fail_retry_cnt: got %0d want %0d", retry_cnt, MAX_RETRY); end
            n_checks++; if (tx_data !== '0) begin n_fail++; $display("FAIL fail_tx: got %h want 0", tx_data); end
            n_checks++; if (align_rst_n !== 1'b0) begin n_fail++; $display("FAIL fail_align: got %b want 0", align_rst_n); end
            step();
        end
        start = 1'b1; step(); start = 1'b0;
        n_checks++; if (state !== ST_RST) begin n_fail++; $display("FAIL restart_state: got %0d want %0d", state, ST_RST); end
        n_checks++; if (retry_cnt !== 3'd0) begin n_fail++; $display("FAIL restart_retry_cnt: got %0d want 0", retry_cnt); end
        n_checks++; if (link_fail !== 1'b0) begin n_fail++; $display("FAIL restart_link_fail: got %b want 0", link_fail); end
        n_checks++; if (tx_data !== P5) begin n_fail++; $display("FAIL restart_tx: got %h want %h", tx_data, P5); end
    endtask

    task automatic test_verify_glitch();
        int g, h, d;
        logic [W-1:0] words[$];
        logic [W-1:0] cur;
        repeat (4) step();
        n_checks++; if (state !== ST_SEARCH) begin n_fail++; $display("FAIL glitch_search: got %0d want %0d", state, ST_SEARCH); end
        d = $urandom_range(0, 20);
        repeat (d) step();
        align_aligned = 1'b1; step();
        n_checks++; if (state !== ST_VERIFY) begin n_fail++; $display("FAIL glitch_verify_entry: got %0d want %0d", state, ST_VERIFY); end
        loopback = 1'b0;
        g = $urandom_range(1, VERIFY_N - 1);
        cur = ($urandom_range(0, 1) == 1) ? PA : P5;
        for (int i = 0; i < g; i++) begin words.push_back(cur); cur = (cur == P5) ? PA : P5; end
        if ($urandom_range(0, 3) != 0) words.push_back(words[g - 1]);
        else words.push_back(rand_word());
        for (int i = 0; i < VERIFY_N + 2; i++) begin words.push_back(cur); cur = (cur == P5) ? PA : P5; end
        h = g + VERIFY_N;
        for (int i = 0; i <= h; i++) begin
            rx_drv = words[i];
            n_checks++; if (state !== ST_VERIFY) begin n_fail++; $display("FAIL glitch_verify_state: got %0d at word %0d", state, i); end
            step();
        end
        n_checks++; if (state !== ST_HOLD) begin n_fail++; $display("FAIL glitch_hold_entry: got %0d want %0d", state, ST_HOLD); end
    endtask

    task automatic test_hold_reset();
        int n;
        n = $urandom_range(0, HOLD_CYCLES - 2);
        repeat (n) step();
        n_checks++; if (state !== ST_HOLD) begin n_fail++; $display("FAIL hold_before_reset: got %0d want %0d", state, ST_HOLD); end
        reset = 1'b0; step();
        n_checks++; if (state !== ST_IDLE) begin n_fail++; $display("FAIL hold_reset_state: got %0d want %0d", state, ST_IDLE); end
        n_checks++; if (tx_data !== '0) begin n_fail++; $display("FAIL hold_reset_tx: got %h want 0", tx_data); end
        n_checks++; if (align_rst_n !== 1'b0) begin n_fail++; $display("FAIL hold_reset_align: got %b want 0", align_rst_n); end
        n_checks++; if (link_up !== 1'b0) begin n_fail++; $display("FAIL hold_reset_link_up: got %b want 0", link_up); end
        n_checks++; if (link_fail !== 1'b0) begin n_fail++; $display("FAIL hold_reset_link_fail: got %b want 0", link_fail); end
        n_checks++; if (link_err !== 1'b0) begin n_fail++; $display("FAIL hold_reset_link_err: got %b want 0", link_err); end
        n_checks++; if (retry_cnt !== 3'd0) begin n_fail++; $display("FAIL hold_reset_retry: got %0d want 0", retry_cnt); end
        reset = 1'b1; loopback = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            n_checks++; if (state !== ST_IDLE) begin n_fail++; $display("FAIL hold_reset_idle: got %0d want %0d", state, ST_IDLE); end
        end
        start = 1'b1; step(); start = 1'b0;
        n_checks++; if (state !== ST_RST) begin n_fail++; $display("FAIL hold_reset_restart: got %0d want %0d", state, ST_RST); end
        n_checks++; if (tx_data !== P5) begin n_fail++; $display("FAIL hold_reset_restart_tx: got %h want %h", tx_data, P5); end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; align_aligned = 1'b0; rx_err = 1'b0;
        loopback = 1'b0; rx_drv = '0; tx_payload = '0;
        n_checks = 0; n_fail = 0; cyc = 0; t_link = 0;
        test_reset();
        test_clean_bringup();
        test_window_wrap();
        test_loss_of_link();
        test_timeout_retry();
        test_verify_glitch();
        test_hold_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
